znc_status_reg: RTL
===================

Name: znc_status_reg

Overview:
- Registered ZNC status word for the 16-bit datapath.
- Sits directly downstream of the yellow flag stage. It captures that stage's ZNC_out and feeds the stored value back as that stage's ZNC_in.
- Adds a small shadow stack that saves flags on interrupt entry and restores them on return-from-interrupt.
- Evaluates branch conditions for the fetch stage.

Parameters:
- DEPTH, 4, number of shadow-stack entries (power of 2, ≥2).
- CW, 3, width of the condition-code field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- znc_wr  input  1  load ZNC_new into the flag register this cycle.
- ZNC_new  input  3  new flags from the yellow stage ZNC_out. Bit 2 = Z, bit 1 = N, bit 0 = C.
- push  input  1  interrupt entry: save the current flags.
- pop  input  1  return-from-interrupt: restore the top-of-stack flags.
- cond  input  CW  branch condition code.
- err_clr  input  1  clear the sticky error bits.
- ZNC_q  output  3  current flags, to the yellow stage ZNC_in.
- cond_true  output  1  selected condition holds on ZNC_q.
- depth  output  log2(DEPTH)+1  number of occupied stack entries.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- ovf_err  output  1  sticky flag: a push arrived while full.
- udf_err  output  1  sticky flag: a pop arrived while empty.

Behaviour:
- Reset (asynchronous, immediate):
  - ZNC_q = 000, depth = 0, empty = 1, full = 0, ovf_err = 0, udf_err = 0.
  - Stack contents are don't-care.
- Flag register:
  - Updates on the rising clock edge; ZNC_q reflects a write one cycle after znc_wr.
  - No bypass: ZNC_q never combinationally follows ZNC_new.
- Push (not full):
  - stack[depth] <= ZNC_q (the pre-edge value); depth increments.
  - If znc_wr is also asserted, ZNC_q <= ZNC_new in the same edge. The saved value is the old flags.
- Pop (not empty):
  - ZNC_q <= stack[depth-1]; depth decrements.
  - Pop has priority over znc_wr: ZNC_new is discarded that cycle.
- Push while full:
  - Stack and depth unchanged; ovf_err <= 1.
  - A znc_wr in the same cycle is still honoured.
- Pop while empty:
  - ZNC_q is not restored; depth stays 0; udf_err <= 1.
  - A znc_wr in the same cycle is honoured, because no restore occurs.
- push and pop in the same cycle:
  - Stack and depth unchanged, no error set.
  - ZNC_q is governed by znc_wr alone.
- Errors:
  - err_clr clears both sticky bits on the next edge.
  - If a new error and err_clr coincide, the error wins (bit stays 1).
- depth never wraps; full and empty are decoded from depth combinationally.
- cond_true is combinational from cond and ZNC_q, with zero latency:
  - 000 always
  - 001 EQ (Z)
  - 010 NE (!Z)
  - 011 MI (N)
  - 100 PL (!N)
  - 101 CS (C)
  - 110 CC (!C)
  - 111 never
- Reset asserted mid-operation (e.g. during a push):
  - All state returns to reset values immediately; the partial push is lost.
  - After deassertion, the first edge behaves as a normal cycle.

Decomposition:
- Shared package holds:
  - Flag bit indices: Z_BIT = 2, N_BIT = 1, C_BIT = 0.
  - Condition-code constants COND_AL … COND_NV.
  - The ZNC reset value 3'b000.
- The yellow stage's opCode decoding also consumes the flag indices from this package.
- One combinational sub-module, cond_eval (cond, ZNC → cond_true), is natural and reusable by the branch unit.
- The stack array and pointer logic stay inline.

Test Plan:
- Flag write and latency: reset; znc_wr = 1, ZNC_new = 101.
  - ZNC_q = 000 before the edge and 101 after it.
  - cond = 001 gives cond_true = 1; cond = 100 gives cond_true = 1; cond = 111 gives cond_true = 0.
- Save and restore: ZNC_q = 010.
  - push with znc_wr = 1, ZNC_new = 111 → ZNC_q = 111, depth = 1.
  - pop with znc_wr = 1, ZNC_new = 001 → ZNC_q = 010 (pop wins), depth = 0, empty = 1.
- Overflow: DEPTH = 4; five pushes with flags 001, 010, 011, 100, 101.
  - After the fifth: full = 1, ovf_err = 1, depth = 4.
  - Four pops return ZNC_q = 100, 011, 010, 001 in that order.
- Underflow and sticky error: pop when empty with ZNC_q = 110.
  - ZNC_q stays 110; udf_err = 1 and remains 1 for 3 idle cycles.
  - err_clr → udf_err = 0 next cycle.
  - err_clr together with another empty pop → udf_err stays 1.
- Simultaneous push and pop at depth = 2, with znc_wr = 1, ZNC_new = 011:
  - depth stays 2, ZNC_q = 011, no error.
- Asynchronous reset mid-push at depth = 3:
  - ZNC_q = 000, depth = 0, empty = 1 before the next clock edge.
  - The next pop sets udf_err.

Source files
------------

// File: rtl/znc_status_reg_pkg.sv
// Shared definitions for the ZNC status word: flag bit positions, condition
// codes and the flag reset value.
package znc_status_reg_pkg;

   localparam int unsigned ZNC_W = 3;

   localparam int unsigned Z_BIT = 2;
   localparam int unsigned N_BIT = 1;
   localparam int unsigned C_BIT = 0;

   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_MI = 3'b011;
   localparam logic [2:0] COND_PL = 3'b100;
   localparam logic [2:0] COND_CS = 3'b101;
   localparam logic [2:0] COND_CC = 3'b110;
   localparam logic [2:0] COND_NV = 3'b111;

   typedef logic [ZNC_W-1:0] znc_t;

   localparam znc_t ZNC_RST = 3'b000;

endpackage

// File: rtl/znc_status_reg_cond_eval.sv
// Combinational branch-condition evaluator: maps a condition code and the
// current ZNC flags onto a single taken/not-taken bit.
module znc_status_reg_cond_eval
   import znc_status_reg_pkg::*;
#(
   parameter int unsigned CW = 3
) (
   input  logic [CW-1:0] cond,
   input  znc_t          znc,
   output logic          cond_true
);

   always_comb begin
      cond_true = 1'b0;
      // Codes outside the defined set (only possible when CW > 3) never hold.
      case (cond)
         CW'(COND_AL): cond_true = 1'b1;
         CW'(COND_EQ): cond_true = znc[Z_BIT];
         CW'(COND_NE): cond_true = ~znc[Z_BIT];
         CW'(COND_MI): cond_true = znc[N_BIT];
         CW'(COND_PL): cond_true = ~znc[N_BIT];
         CW'(COND_CS): cond_true = znc[C_BIT];
         CW'(COND_CC): cond_true = ~znc[C_BIT];
         default:      cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/znc_status_reg.sv
// Registered ZNC status word with an interrupt shadow stack, sticky
// overflow/underflow flags and a combinational branch-condition output.
module znc_status_reg
   import znc_status_reg_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     znc_wr,
   input  logic [2:0]               ZNC_new,
   input  logic                     push,
   input  logic                     pop,
   input  logic [CW-1:0]            cond,
   input  logic                     err_clr,
   output logic [2:0]               ZNC_q,
   output logic                     cond_true,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf_err,
   output logic                     udf_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   znc_t          znc_q, znc_d;
   logic [AW:0]   depth_q, depth_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   znc_t          stack_q [DEPTH];

   logic          do_push, do_pop, ovf_set, udf_set;
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign full  = (depth_q == (AW+1)'(DEPTH));
   assign empty = (depth_q == '0);

   // A simultaneous push and pop cancels out: no stack movement, no error.
   assign do_push = push & ~pop & ~full;
   assign do_pop  = pop & ~push & ~empty;
   assign ovf_set = push & ~pop & full;
   assign udf_set = pop & ~push & empty;

   // When full the low bits wrap to 0, so rd_ptr correctly lands on DEPTH-1.
   assign wr_ptr = depth_q[AW-1:0];
   assign rd_ptr = wr_ptr - 1'b1;

   always_comb begin
      znc_d   = znc_q;
      depth_d = depth_q;
      if (do_pop) begin
         znc_d   = stack_q[rd_ptr];
         depth_d = depth_q - 1'b1;
      end else if (znc_wr) begin
         znc_d = ZNC_new;
      end
      if (do_push) begin
         depth_d = depth_q + 1'b1;
      end
      // A new error beats a coincident clear.
      ovf_d = ovf_set | (ovf_q & ~err_clr);
      udf_d = udf_set | (udf_q & ~err_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         znc_q   <= ZNC_RST;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         znc_q   <= znc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Stack contents are don't-care after reset, so the array has no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         stack_q[wr_ptr] <= znc_q;
      end
   end

   znc_status_reg_cond_eval #(
      .CW (CW)
   ) u_cond_eval (
      .cond      (cond),
      .znc       (znc_q),
      .cond_true (cond_true)
   );

   assign ZNC_q   = znc_q;
   assign depth   = depth_q;
   assign ovf_err = ovf_q;
   assign udf_err = udf_q;

endmodule
